uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameters SHALL be:
- ECHO_DEPTH, default 4, depth of the echo byte FIFO (power of 2, 2..16).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- time_data  in  24  {hour[23:19], min[18:13], sec[12:7], centisec[6:0]}, binary.
- report_req  in  1  1-cycle pulse requesting one time-report frame.
- echo_valid  in  1  1-cycle pulse; echo_data is valid.
- echo_data  in  8  byte to echo back.
- tx_busy  in  1  UART transmitter busy.
- tx_done  in  1  1-cycle pulse when the transmitter finishes a byte.
- tx_start  out  1  1-cycle pulse to launch tx_data.
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_done.
- report_busy  out  1  high from report acceptance until the last byte's tx_done.
- echo_drop  out  1  1-cycle pulse when an echo byte is lost because the FIFO is full.

Function
REQ-003 The block SHALL share one UART transmitter between two requesters: the echo FIFO and the report frame.
REQ-004 The FSM SHALL have states IDLE, ARB, LOAD, START, WAIT_DONE.
- IDLE -> ARB when any request is pending.
- ARB -> LOAD on grant.
- LOAD -> START once the byte is registered.
- START -> WAIT_DONE issuing tx_start, only when tx_busy=0; otherwise it stalls in START.
- WAIT_DONE -> LOAD on tx_done if report bytes remain; otherwise -> IDLE.
REQ-005 Arbitration in ARB SHALL be round-robin on a last-grant flag; on the first arbitration after reset, echo wins ties.
REQ-006 A report frame SHALL be atomic: no echo byte is interleaved once its first byte is loaded.
REQ-007 A report grant SHALL snapshot time_data in ARB; all frame digits come from that snapshot.
REQ-008 The frame SHALL be ASCII "HH:MM:SS.CC", each field as two decimal digits 0x30..0x39 with a leading zero.
REQ-009 Fields with a binary value above 99 are not required to display correctly; hour>23, min>59 and sec>59 SHALL still be transmitted as their two-digit decimal values.
REQ-010 A report_req that arrives while a report is pending or active SHALL be ignored; report_busy is set the cycle after an accepted report_req.
REQ-011 The echo FIFO SHALL accept echo_valid whenever not full.
- When full, the byte is discarded and echo_drop pulses the following cycle.
- A push and a pop in the same cycle SHALL both succeed.
REQ-012 Latency from report_req (cycle N), with the block idle and tx_busy=0, SHALL put the first tx_start at cycle N+4.
REQ-013 A tx_done arriving outside WAIT_DONE SHALL be ignored.

Reset
REQ-014 While rst=0, all of the following SHALL hold:
- tx_start=0, tx_data=0x00, report_busy=0, echo_drop=0.
- FIFO empty, snapshot=0, byte index=0, last-grant flag=report, FSM=IDLE.
REQ-015 Reset asserted mid-frame SHALL abort the frame immediately; no byte is resumed after release.

Configuration
REQ-016 Macro UART_TX_SCHEDULER_EOL_EN:
- Defined: the report frame SHALL append CR (0x0D) and LF (0x0A), 13 bytes total.
- Undefined: the frame SHALL be exactly 11 bytes.

Structure
REQ-017 The shared package SHALL hold:
- the FSM state enum;
- ASCII constants for '0', ':', '.', CR and LF;
- frame-length constants for 11 and 13 bytes;
- time_data field bit positions.
REQ-018 Conversion of a 7-bit value 0..99 to two ASCII digits SHALL be one combinational sub-module, bin2ascii_2dig, instantiated per field.

Verification
REQ-019 Directed scenarios the bench SHALL cover:
- time_data={5'd9,6'd5,6'd30,7'd7}, one report_req, EOL on -> bytes "09:05:30.07" 0x0D 0x0A, report_busy falls after the 13th tx_done.
- report_req at N, idle, tx_busy=0 -> tx_start at N+4; tx_busy held 1 for 10 cycles -> tx_start delayed until tx_busy=0.
- 6 echo_valid back-to-back (0x41..0x46), ECHO_DEPTH=4, transmitter stalled -> 0x41..0x44 sent in order, echo_drop pulses twice.
- echo 0x61 and report_req on the same cycle after reset -> 0x61 first, then the full frame; echo 0x62 pushed mid-frame is sent after the frame's last byte.
- second report_req during a frame -> ignored, exactly one frame sent; time_data changed mid-frame -> digits match the snapshot.
- rst asserted at the 5th byte -> outputs at reset values, FSM IDLE; after release, a new report_req sends a complete fresh frame.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, ASCII
// constants, report frame lengths and the time_data field layout.
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        LOAD      = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4
    } state_e;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int unsigned FRAME_LEN_BASE = 11;
    localparam int unsigned FRAME_LEN_EOL  = 13;
    localparam int unsigned IDX_W          = 4;

    localparam int unsigned TIME_W   = 24;
    localparam int unsigned HOUR_MSB = 23;
    localparam int unsigned HOUR_LSB = 19;
    localparam int unsigned MIN_MSB  = 18;
    localparam int unsigned MIN_LSB  = 13;
    localparam int unsigned SEC_MSB  = 12;
    localparam int unsigned SEC_LSB  = 7;
    localparam int unsigned CS_MSB   = 6;
    localparam int unsigned CS_LSB   = 0;

endpackage

// File: rtl/uart_tx_scheduler_bin2ascii_2dig.sv
// bin2ascii_2dig: combinational conversion of a 7-bit value 0..99 into two
// ASCII decimal digits with a leading zero.
//   bin_i      7-bit binary value
//   tens_c_o   ASCII tens digit
//   ones_c_o   ASCII ones digit
module bin2ascii_2dig
    import uart_tx_scheduler_pkg::*;
(
    input  logic [6:0] bin_i,
    output logic [7:0] tens_c_o,
    output logic [7:0] ones_c_o
);

    logic [6:0] tens;
    logic [6:0] ones;

    always_comb begin
        tens     = bin_i / 7'd10;
        ones     = bin_i - 7'(tens * 7'd10);
        tens_c_o = ASCII_ZERO + {1'b0, tens};
        ones_c_o = ASCII_ZERO + {1'b0, ones};
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between an echo byte FIFO
// and an atomic "HH:MM:SS.CC" time-report frame, round-robin arbitrated.
// Optional macro UART_TX_SCHEDULER_EOL_EN appends CR LF to the report frame.
// Ports:
//   clk, rst (async active-low)
//   time_data[23:0]  {hour, min, sec, centisec}, snapshotted on report grant
//   report_req       pulse: request one report frame
//   echo_valid/echo_data  pulse + byte to echo
//   tx_busy, tx_done transmitter status
//   tx_start/tx_data byte launch to the transmitter
//   report_busy      report accepted and not yet fully transmitted
//   echo_drop        pulse: echo byte lost to a full FIFO
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned ECHO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] time_data,
    input  logic              report_req,
    input  logic              echo_valid,
    input  logic [7:0]        echo_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              report_busy,
    output logic              echo_drop
);

`ifdef UART_TX_SCHEDULER_EOL_EN
    localparam int unsigned FRAME_LEN = FRAME_LEN_EOL;
`else
    localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam int unsigned PTR_W = (ECHO_DEPTH > 1) ? $clog2(ECHO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ECHO_DEPTH);

    state_e             state_q, state_d;
    logic [TIME_W-1:0]  snap_q, snap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_rpt_q, last_rpt_d;
    logic               grant_rpt_q, grant_rpt_d;
    logic               report_busy_q, report_busy_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               echo_drop_q;

    logic [7:0]         mem_q [ECHO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               fifo_empty, fifo_full, push, pop, report_accept;
    logic [7:0]         frame_byte;
    logic [7:0]         hour_t, hour_o, min_t, min_o, sec_t, sec_o, cs_t, cs_o;

    assign fifo_empty    = (cnt_q == '0);
    assign fifo_full     = (cnt_q == FULL_CNT);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push          = echo_valid & (~fifo_full | pop);
    assign report_accept = report_req & ~report_busy_q;

    bin2ascii_2dig u_hour (.bin_i({2'b00, snap_q[HOUR_MSB:HOUR_LSB]}), .tens_c_o(hour_t), .ones_c_o(hour_o));
    bin2ascii_2dig u_min  (.bin_i({1'b0, snap_q[MIN_MSB:MIN_LSB]}),   .tens_c_o(min_t),  .ones_c_o(min_o));
    bin2ascii_2dig u_sec  (.bin_i({1'b0, snap_q[SEC_MSB:SEC_LSB]}),   .tens_c_o(sec_t),  .ones_c_o(sec_o));
    bin2ascii_2dig u_cs   (.bin_i(snap_q[CS_MSB:CS_LSB]),             .tens_c_o(cs_t),   .ones_c_o(cs_o));

    // Report frame byte selected by the byte index.
    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            4'd0:    frame_byte = hour_t;
            4'd1:    frame_byte = hour_o;
            4'd2:    frame_byte = ASCII_COLON;
            4'd3:    frame_byte = min_t;
            4'd4:    frame_byte = min_o;
            4'd5:    frame_byte = ASCII_COLON;
            4'd6:    frame_byte = sec_t;
            4'd7:    frame_byte = sec_o;
            4'd8:    frame_byte = ASCII_DOT;
            4'd9:    frame_byte = cs_t;
            4'd10:   frame_byte = cs_o;
            4'd11:   frame_byte = ASCII_CR;
            4'd12:   frame_byte = ASCII_LF;
            default: frame_byte = 8'h00;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        idx_d         = idx_q;
        last_rpt_d    = last_rpt_q;
        grant_rpt_d   = grant_rpt_q;
        report_busy_d = report_busy_q | report_accept;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        pop           = 1'b0;

        case (state_q)
            IDLE: begin
                // Incoming requests are looked at directly to save a cycle of latency.
                if (report_busy_q | report_accept | ~fifo_empty | echo_valid) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                // In ARB report_busy can only mean "pending", never "active".
                if (report_busy_q && (fifo_empty || !last_rpt_q)) begin
                    grant_rpt_d = 1'b1;
                    last_rpt_d  = 1'b1;
                    snap_d      = time_data;
                    idx_d       = '0;
                    state_d     = LOAD;
                end else if (!fifo_empty) begin
                    grant_rpt_d = 1'b0;
                    last_rpt_d  = 1'b0;
                    state_d     = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                tx_data_d = grant_rpt_q ? frame_byte : mem_q[rd_ptr_q];
                state_d   = START;
            end
            START: begin
                // The echo head stays in the FIFO until launched, so a stall keeps it occupied.
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    pop        = ~grant_rpt_q;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (grant_rpt_q && (idx_q != LAST_IDX)) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LOAD;
                    end else begin
                        if (grant_rpt_q) begin
                            report_busy_d = 1'b0;
                            idx_d         = '0;
                        end
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q        <= '0;
            idx_q         <= '0;
            last_rpt_q    <= 1'b1;
            grant_rpt_q   <= 1'b0;
            report_busy_q <= 1'b0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
        end else begin
            snap_q        <= snap_d;
            idx_q         <= idx_d;
            last_rpt_q    <= last_rpt_d;
            grant_rpt_q   <= grant_rpt_d;
            report_busy_q <= report_busy_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
        end
    end

    // Echo FIFO pointers, occupancy and drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            echo_drop_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            echo_drop_q <= echo_valid & ~push;
        end
    end

    // Echo FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= echo_data;
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign report_busy = report_busy_q;
    assign echo_drop   = echo_drop_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple transmitter model.
module tb_uart_tx_scheduler;
    import uart_tx_scheduler_pkg::*;

`ifdef UART_TX_SCHEDULER_EOL_EN
    localparam int unsigned FLEN = 13;
`else
    localparam int unsigned FLEN = 11;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] time_data;
    logic        report_req, echo_valid;
    logic [7:0]  echo_data;
    logic        tx_busy, tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        report_busy, echo_drop;
    logic        force_busy, model_busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          drop_cnt = 0;
    logic [7:0]  cap [$];

    // "09:05:30.07", "23:59:58.99", "31:63:60.00", each followed by CR LF
    logic [7:0] F1 [13] = '{8'h30, 8'h39, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h33, 8'h30, 8'h2E, 8'h30, 8'h37, 8'h0D, 8'h0A};
    logic [7:0] F2 [13] = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h38, 8'h2E, 8'h39, 8'h39, 8'h0D, 8'h0A};
    logic [7:0] F3 [13] = '{8'h33, 8'h31, 8'h3A, 8'h36, 8'h33, 8'h3A, 8'h36, 8'h30, 8'h2E, 8'h30, 8'h30, 8'h0D, 8'h0A};

    assign tx_busy = force_busy | model_busy;

    uart_tx_scheduler #(.ECHO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .time_data  (time_data),
        .report_req (report_req),
        .echo_valid (echo_valid),
        .echo_data  (echo_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .report_busy(report_busy),
        .echo_drop  (echo_drop)
    );

    initial forever #5 clk = ~clk;

    // Transmitter model: busy for 3 cycles after tx_start, then a tx_done pulse.
    initial begin
        int cnt;
        cnt = 0;
        model_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst !== 1'b1) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    done_cnt++;
                end
            end else if (tx_start === 1'b1) begin
                cnt = 3;
            end
            model_busy = (cnt > 0);
        end
    end

    // Record launched bytes and drop pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) cap.push_back(tx_data);
            if (echo_drop === 1'b1) drop_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_vec++;
        assert (obs === expd) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] cap_at(input int i);
        if (i < cap.size()) return 32'(cap[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check_frame(input string tag, input logic [7:0] f [13], input int base);
        for (int i = 0; i < int'(FLEN); i++) begin
            check($sformatf("%s[%0d]", tag, i), cap_at(base + i), 32'(f[i]));
        end
    endtask

    task automatic wait_busy_low(input int budget);
        int i;
        i = 0;
        while (report_busy === 1'b1 && i < budget) begin
            tick(1);
            i++;
        end
    endtask

    task automatic wait_caps(input int n, input int budget);
        int i;
        i = 0;
        while (cap.size() < n && i < budget) begin
            tick(1);
            i++;
        end
    endtask

    task automatic pulse_report();
        report_req = 1'b1;
        tick(1);
        report_req = 1'b0;
    endtask

    initial begin
        int k;
        int d0;
        rst = 1'b0; report_req = 1'b0; echo_valid = 1'b0; echo_data = 8'h00;
        time_data = 24'h0; force_busy = 1'b0;
        tick(3);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_report_busy", 32'(report_busy), 0);
        check("rst_echo_drop", 32'(echo_drop), 0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b1;
        tick(2);

        // Single report: latency, content, busy duration
        cap.delete();
        time_data = {5'd9, 6'd5, 6'd30, 7'd7};
        d0 = done_cnt;
        pulse_report();
        check("s1_busy_set", 32'(report_busy), 1);
        k = 1;
        while (tx_start !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("s1_latency", 32'(k), 4);
        wait_busy_low(400);
        check("s1_busy_fall", 32'(report_busy), 0);
        check("s1_done_count", 32'(done_cnt - d0), 32'(FLEN));
        check("s1_len", 32'(cap.size()), 32'(FLEN));
        check_frame("s1_byte", F1, 0);

        // Transmitter held busy for 10 cycles delays the first launch
        cap.delete();
        force_busy = 1'b1;
        pulse_report();
        tick(9);
        check("s2_no_start", 32'(cap.size()), 0);
        force_busy = 1'b0;
        tick(1);
        k = 1;
        while (tx_start !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("s2_release_latency", 32'(k), 1);
        wait_busy_low(400);
        check("s2_len", 32'(cap.size()), 32'(FLEN));

        // Six echoes into a 4-deep FIFO while stalled
        cap.delete();
        d0 = drop_cnt;
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            echo_valid = 1'b1;
            echo_data  = 8'(8'h41 + i);
            tick(1);
        end
        echo_valid = 1'b0;
        tick(2);
        check("s3_drops", 32'(drop_cnt - d0), 2);
        check("s3_drop_idle", 32'(echo_drop), 0);
        check("s3_stalled", 32'(cap.size()), 0);
        force_busy = 1'b0;
        tick(80);
        check("s3_len", 32'(cap.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s3_byte[%0d]", i), cap_at(i), 32'(8'h41 + i));
        end

        // Echo vs report tie after reset, echo mid-frame, ignored re-request, snapshot
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        cap.delete();
        time_data  = {5'd23, 6'd59, 6'd58, 7'd99};
        echo_valid = 1'b1;
        echo_data  = 8'h61;
        report_req = 1'b1;
        tick(1);
        echo_valid = 1'b0;
        report_req = 1'b0;
        wait_caps(3, 100);
        check("s4_started", 32'(cap.size() >= 3), 1);
        echo_valid = 1'b1;
        echo_data  = 8'h62;
        report_req = 1'b1;
        time_data  = {5'd1, 6'd2, 6'd3, 7'd4};
        tick(1);
        echo_valid = 1'b0;
        report_req = 1'b0;
        tick(400);
        check("s4_busy_fall", 32'(report_busy), 0);
        check("s4_len", 32'(cap.size()), 32'(FLEN + 2));
        check("s4_echo_first", cap_at(0), 32'h61);
        check_frame("s4_frame", F2, 1);
        check("s4_echo_after", cap_at(int'(FLEN) + 1), 32'h62);

        // Reset at the 5th byte, then a fresh frame with out-of-range fields
        cap.delete();
        time_data = {5'd9, 6'd5, 6'd30, 7'd7};
        pulse_report();
        wait_caps(5, 200);
        rst = 1'b0;
        tick(1);
        check("s6_rst_tx_start", 32'(tx_start), 0);
        check("s6_rst_tx_data", 32'(tx_data), 0);
        check("s6_rst_report_busy", 32'(report_busy), 0);
        check("s6_rst_echo_drop", 32'(echo_drop), 0);
        check("s6_rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b1;
        tick(10);
        check("s6_no_resume", 32'(cap.size()), 5);
        cap.delete();
        time_data = {5'd31, 6'd63, 6'd60, 7'd0};
        pulse_report();
        wait_busy_low(400);
        check("s6_busy_fall", 32'(report_busy), 0);
        check("s6_len", 32'(cap.size()), 32'(FLEN));
        check_frame("s6_byte", F3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
